// File: rtl/frame_compositor.sv
// frame_compositor: VGA timing generator and fixed-priority layer merger.
// Generates row/col for the layer generators, samples their colours once per pixel and drives
// registered RGB with aligned active-low hs/vs. Counter widths assume totals up to 1024.
// Optional macro COMPOSITOR_HIT_EN adds the sticky dino/obstacle overlap flag (hit).
module frame_compositor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned PIX_DIV     = 4,
  parameter logic [11:0] TRANSPARENT = 12'hfff,
  parameter logic [11:0] BG_COLOR    = 12'hfff
) (
  input  logic        Clk,
  input  logic        rst,
  output logic [8:0]  row,
  output logic [9:0]  col,
  input  logic [11:0] horizon_px,
  input  logic [11:0] obst_px,
  input  logic [11:0] dino_px,
  input  logic        hit_clr,
  output logic        hit,
  output logic        frame_tick,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW      = $clog2(PIX_DIV);

  localparam logic [PW-1:0] PH_LAST = PW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [PW-1:0] r_phase;
  logic [9:0]    r_hcnt, r_vcnt;
  logic [9:0]    w_hcnt_nxt, w_vcnt_nxt;
  logic [8:0]    r_row;
  logic [9:0]    r_col;
  logic [11:0]   r_rgb;
  logic          r_hs, r_vs, r_frame_tick;
  logic          w_pe, w_active, w_overlap;
  logic [11:0]   w_px;

  // Pixel enable: last Clk of each pixel period.
  always_comb w_pe = (r_phase == PH_LAST);

  // Next raster position; only consumed on pe.
  always_comb begin
    w_hcnt_nxt = r_hcnt + 10'd1;
    w_vcnt_nxt = r_vcnt;
    if (r_hcnt == H_LAST) begin
      w_hcnt_nxt = '0;
      w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
    end
  end

  // Compose the pixel that is ending (current counters) by layer priority.
  always_comb begin
    w_active  = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    w_overlap = w_active && (dino_px != TRANSPARENT) && (obst_px != TRANSPARENT);
    if (dino_px != TRANSPARENT)         w_px = dino_px;
    else if (obst_px != TRANSPARENT)    w_px = obst_px;
    else if (horizon_px != TRANSPARENT) w_px = horizon_px;
    else                                w_px = BG_COLOR;
  end

  // Clock divider phase.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst)      r_phase <= '0;
    else if (w_pe) r_phase <= '0;
    else           r_phase <= r_phase + PW'(1);
  end

  // Raster counters and the row/col presented to the layer generators.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_pe) begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      r_col  <= (w_hcnt_nxt < H_ACT) ? w_hcnt_nxt : 10'h3ff;
      r_row  <= (w_vcnt_nxt < V_ACT) ? w_vcnt_nxt[8:0] : 9'h1ff;
    end
  end

  // Colour and sync outputs, one pixel behind row/col so all five stay aligned.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_rgb        <= '0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_pe && (r_hcnt == H_LAST) && (r_vcnt == V_ACT_LAST);
      if (w_pe) begin
        r_rgb <= w_active ? w_px : 12'h000;
        r_hs  <= !((r_hcnt >= HS_START) && (r_hcnt < HS_END));
        r_vs  <= !((r_vcnt >= VS_START) && (r_vcnt < VS_END));
      end
    end
  end

`ifdef COMPOSITOR_HIT_EN
  logic r_hit;

  // Sticky overlap flag; a new overlap beats a simultaneous clear.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst)                   r_hit <= 1'b0;
    else if (w_pe && w_overlap) r_hit <= 1'b1;
    else if (hit_clr)           r_hit <= 1'b0;
  end

  assign hit = r_hit;
`else
  logic w_unused;
  assign w_unused = hit_clr ^ w_overlap;
  assign hit      = 1'b0;
`endif

  assign row        = r_row;
  assign col        = r_col;
  assign hs         = r_hs;
  assign vs         = r_vs;
  assign frame_tick = r_frame_tick;
  assign r          = r_rgb[11:8];
  assign g          = r_rgb[7:4];
  assign b          = r_rgb[3:0];

endmodule

// File: tb/tb_frame_compositor.sv
// Randomized scoreboard bench for frame_compositor with a reduced raster so several frames fit.
// Expected outputs come from a raster-arithmetic model keyed on Clk count since reset release.
module tb_frame_compositor;

  localparam int HA = 16, HFP = 2, HSY = 4, HBP = 3;
  localparam int VA = 8, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int PD = 4;
  localparam logic [11:0] TR = 12'hfff;

  logic        Clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] horizon_px, obst_px, dino_px;
  logic        hit_clr;
  logic [8:0]  row;
  logic [9:0]  col;
  logic        hit, frame_tick, hs, vs;
  logic [3:0]  r, g, b;

  frame_compositor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .PIX_DIV(PD), .TRANSPARENT(12'hfff), .BG_COLOR(12'hfff)
  ) dut (
    .Clk(Clk), .rst(rst), .row(row), .col(col),
    .horizon_px(horizon_px), .obst_px(obst_px), .dino_px(dino_px),
    .hit_clr(hit_clr), .hit(hit), .frame_tick(frame_tick),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        ft;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state
  int          e;
  logic [11:0] m_rgb;
  logic        m_hs, m_vs, m_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    e = 0; m_rgb = 12'h000; m_hs = 1'b1; m_vs = 1'b1; m_hit = 1'b0;
  endtask

  function automatic logic [11:0] pick(input int pct_tr);
    int c;
    if ($urandom_range(99) < pct_tr) return TR;
    c = $urandom_range(4);
    case (c)
      0: return 12'h000;
      1: return 12'hf00;
      2: return 12'h048;
      3: return 12'h0f0;
      default: return 12'($urandom);
    endcase
  endfunction

  // One Clk: predict outputs after the edge from the inputs present at it, then drive new inputs.
  task automatic step(input int pd, input int po, input int pc);
    exp_t x;
    int   p, h, v, n;
    logic act, ft;
    @(posedge Clk);
    #1;
    e++;
    ft = 1'b0;
`ifdef COMPOSITOR_HIT_EN
    if (hit_clr) m_hit = 1'b0;
`endif
    if (e % PD == 0) begin
      p = e / PD - 1;
      h = p % HT;
      v = (p / HT) % VT;
      act = (h < HA) && (v < VA);
      if (!act)                m_rgb = 12'h000;
      else if (dino_px != TR)  m_rgb = dino_px;
      else if (obst_px != TR)  m_rgb = obst_px;
      else if (horizon_px != TR) m_rgb = horizon_px;
      else                     m_rgb = 12'hfff;
      m_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
      m_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
      ft   = (h == HT - 1) && (v == VA - 1);
`ifdef COMPOSITOR_HIT_EN
      if (act && dino_px != TR && obst_px != TR) m_hit = 1'b1;
`endif
    end
    n = e / PD;
    h = n % HT;
    v = (n / HT) % VT;
    x.rgb = m_rgb;
    x.hs  = m_hs;
    x.vs  = m_vs;
    x.row = (v < VA) ? 9'(v) : 9'h1ff;
    x.col = (h < HA) ? 10'(h) : 10'h3ff;
    x.ft  = ft;
    x.hit = m_hit;
    q.push_back(x);
    dino_px    = pick(pd);
    obst_px    = pick(po);
    horizon_px = pick(40);
    hit_clr    = ($urandom_range(99) < pc);
  endtask

  task automatic run(input int cycles, input int pd, input int po, input int pc);
    for (int i = 0; i < cycles; i++) step(pd, po, pc);
  endtask

  task automatic check_reset_values();
    check("rst_hs", hs, 1'b1);
    check("rst_vs", vs, 1'b1);
    check("rst_rgb", {r, g, b}, 12'h000);
    check("rst_row", row, 9'h000);
    check("rst_col", col, 10'h000);
    check("rst_hit", hit, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);
  endtask

  // Monitor: compare every Clk away from the active edge while out of reset.
  always @(negedge Clk) begin
    exp_t x;
    if (rst && q.size() > 0) begin
      x = q.pop_front();
      check("rgb", {r, g, b}, x.rgb);
      check("hs", hs, x.hs);
      check("vs", vs, x.vs);
      check("row", row, x.row);
      check("col", col, x.col);
      check("frame_tick", frame_tick, x.ft);
      check("hit", hit, x.hit);
    end
  end

  initial begin
    horizon_px = TR; obst_px = TR; dino_px = TR; hit_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_values();
    #1 rst = 1'b1;
    // Two-plus frames of mixed traffic with occasional clears.
    run(3200, 60, 50, 3);
    // Mid-frame reset.
    @(negedge Clk);
    #1 rst = 1'b0;
    q.delete();
    #2 check_reset_values();
    repeat (2) @(negedge Clk);
    model_reset();
    #1 rst = 1'b1;
    // No dino pixels: hit must stay clear once cleared.
    run(1600, 100, 50, 20);
    // Dense overlaps with frequent clears, exercising set/clear coincidence.
    run(1600, 30, 30, 10);
    // Blanking-heavy colour patterns with plain inputs.
    run(1600, 70, 70, 2);
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
